uart_rx: RTL and testbench

UART receiver; the receive-side counterpart of the existing transmitter. Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous serial input at CLKS_PER_BIT clocks per bit. Presents each good byte with a one-cycle valid strobe and flags bad stop bits. Sits between the board RX pin and the puzzle-input loader logic.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. Recovers start / 8 data bits (LSB first) /
//            stop frames from an asynchronous serial line at CLKS_PER_BIT
//            clocks per bit. Each good byte is presented with a one-cycle
//            valid strobe. A low stop bit raises a one-cycle framing-error
//            strobe and the frame is discarded.
// Ports    : clk           - system clock, rising edge
//            reset_n       - asynchronous active-low reset
//            uart_input    - raw serial line (asynchronous, idle high)
//            received_byte - last correctly framed byte, held between frames
//            byte_valid    - 1-cycle pulse, received_byte just updated
//            framing_error - 1-cycle pulse, stop bit sampled low
//            busy          - high whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_input,
  output logic [7:0] received_byte,
  output logic       byte_valid,
  output logic       framing_error,
  output logic       busy
);

  // Mid-start-bit offset; later samples fall one full bit period apart,
  // so every data and stop sample lands near the middle of its bit.
  localparam logic [15:0] c_half_count = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] c_last_count = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_BIT = 3'd1,
    S_DATA_BITS = 3'd2,
    S_STOP_BIT  = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] clock_count_q, clock_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  received_byte_q, received_byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        framing_error_q, framing_error_d;

  // Two-flop synchroniser; reset to the idle (high) line level so a reset
  // release never looks like a start edge on its own.
  logic        rx_meta_q;
  logic        rx_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_input;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      clock_count_q   <= '0;
      bit_index_q     <= '0;
      shift_q         <= '0;
      received_byte_q <= 8'h00;
      byte_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clock_count_q   <= clock_count_d;
      bit_index_q     <= bit_index_d;
      shift_q         <= shift_d;
      received_byte_q <= received_byte_d;
      byte_valid_q    <= byte_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    clock_count_d   = clock_count_q;
    bit_index_d     = bit_index_q;
    shift_d         = shift_q;
    received_byte_d = received_byte_q;
    byte_valid_d    = 1'b0;
    framing_error_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clock_count_d = '0;
        if (!rx_sync_q) begin
          state_d = S_START_BIT;
        end
      end

      S_START_BIT: begin
        if (clock_count_q == c_half_count) begin
          clock_count_d = '0;
          if (!rx_sync_q) begin
            state_d     = S_DATA_BITS;
            bit_index_d = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          clock_count_d = clock_count_q + 16'd1;
        end
      end

      S_DATA_BITS: begin
        if (clock_count_q == c_last_count) begin
          clock_count_d          = '0;
          shift_d[bit_index_q]   = rx_sync_q;
          if (bit_index_q == 3'd7) begin
            state_d = S_STOP_BIT;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clock_count_d = clock_count_q + 16'd1;
        end
      end

      S_STOP_BIT: begin
        if (clock_count_q == c_last_count) begin
          clock_count_d = '0;
          // Leaving at mid-stop-bit leaves half a bit of slack so a
          // back-to-back start edge is still seen from IDLE.
          if (rx_sync_q) begin
            received_byte_d = shift_q;
            byte_valid_d    = 1'b1;
            state_d         = S_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = S_WAIT_IDLE;
          end
        end else begin
          clock_count_d = clock_count_q + 16'd1;
        end
      end

      S_WAIT_IDLE: begin
        // A held-low (break) line must not retrigger frames.
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign received_byte = received_byte_q;
  assign byte_valid    = byte_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx at 16 clocks per bit. Stimulus
//            pushes expected output events into a scoreboard queue; a monitor
//            pops and compares each time the receiver pulses an output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLKS_PER_BIT = 16;

  logic       clk;
  logic       reset_n;
  logic       uart_input;
  logic [7:0] received_byte;
  logic       byte_valid;
  logic       framing_error;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .uart_input    (uart_input),
    .received_byte (received_byte),
    .byte_valid    (byte_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   valid_cycles[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  logic prev_bv  = 1'b0;
  logic prev_fe  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every output pulse against the scoreboard head.
  always @(negedge clk) begin
    cycle++;
    if (reset_n) begin
      if (byte_valid || framing_error) begin
        checks++;
        if (byte_valid && framing_error) begin
          failures++;
          $display("FAIL both_pulses: byte_valid=1 framing_error=1 expected only one");
        end else if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: byte_valid=%0b framing_error=%0b byte=0x%0h expected none",
                   byte_valid, framing_error, received_byte);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.is_err != framing_error) begin
            failures++;
            $display("FAIL pulse_kind: framing_error=%0b expected %0b", framing_error, e.is_err);
          end else if (!e.is_err && received_byte !== e.data) begin
            failures++;
            $display("FAIL rx_byte: got 0x%0h expected 0x%0h", received_byte, e.data);
          end
        end
        if (byte_valid) valid_cycles.push_back(cycle);
      end
      if ((byte_valid && prev_bv) || (framing_error && prev_fe)) begin
        checks++;
        failures++;
        $display("FAIL pulse_width: strobe high for more than 1 cycle, expected 1");
      end
    end
    prev_bv = byte_valid;
    prev_fe = framing_error;
  end

  // mode 0: 16 clocks/bit, mode 1: alternating 17/16, mode 2: alternating 15/16
  task automatic send_frame(input logic [7:0] b, input bit stop_val, input int mode);
    for (int i = 0; i < 10; i++) begin
      int len;
      if (i == 0)      uart_input = 1'b0;
      else if (i == 9) uart_input = stop_val;
      else             uart_input = b[i-1];
      if (mode == 1)      len = (i % 2 == 0) ? 17 : 16;
      else if (mode == 2) len = (i % 2 == 0) ? 15 : 16;
      else                len = CLKS_PER_BIT;
      repeat (len) @(negedge clk);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    sb.push_back(e);
  endtask

  initial begin
    int n0;
    uart_input = 1'b1;
    reset_n    = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_byte",  {24'd0, received_byte}, 32'h00);
    check("reset_valid", {31'd0, byte_valid},    32'd0);
    check("reset_ferr",  {31'd0, framing_error}, 32'd0);
    check("reset_busy",  {31'd0, busy},          32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single frame 0x41
    push_byte(8'h41);
    send_frame(8'h41, 1'b1, 0);
    check("busy_after_41", {31'd0, busy}, 32'd0);
    check("byte_41", {24'd0, received_byte}, 32'h41);
    repeat (20) @(negedge clk);

    // Back-to-back 0xA5, 0x3C
    n0 = valid_cycles.size();
    push_byte(8'hA5);
    push_byte(8'h3C);
    send_frame(8'hA5, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("b2b_count", valid_cycles.size(), n0 + 2);
    if (valid_cycles.size() == n0 + 2) begin
      int d;
      d = valid_cycles[n0+1] - valid_cycles[n0];
      check("b2b_spacing_ok", {31'd0, (d >= 159 && d <= 161)}, 32'd1);
    end
    check("byte_3C", {24'd0, received_byte}, 32'h3C);

    // 4-clock low glitch
    uart_input = 1'b0;
    repeat (4) @(negedge clk);
    uart_input = 1'b1;
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_byte_kept", {24'd0, received_byte}, 32'h3C);

    // 0x55 with low stop bit, line held low 64 more clocks
    push_err();
    send_frame(8'h55, 1'b0, 0);
    uart_input = 1'b0;
    repeat (64) @(negedge clk);
    check("break_busy_high", {31'd0, busy}, 32'd1);
    check("ferr_byte_kept", {24'd0, received_byte}, 32'h3C);
    uart_input = 1'b1;
    repeat (4) @(negedge clk);
    check("break_busy_low", {31'd0, busy}, 32'd0);
    repeat (16) @(negedge clk);
    push_byte(8'h0F);
    send_frame(8'h0F, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("byte_0F", {24'd0, received_byte}, 32'h0F);

    // Reset during bit 3 of 0xFF
    uart_input = 1'b0;
    repeat (16) @(negedge clk);
    uart_input = 1'b1;
    repeat (3 * 16 + 8) @(negedge clk);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_byte",  {24'd0, received_byte}, 32'h00);
    check("rst_mid_busy",  {31'd0, busy},          32'd0);
    check("rst_mid_valid", {31'd0, byte_valid},    32'd0);
    check("rst_mid_ferr",  {31'd0, framing_error}, 32'd0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_byte", {24'd0, received_byte}, 32'h00);
    push_byte(8'h12);
    send_frame(8'h12, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("byte_12", {24'd0, received_byte}, 32'h12);

    // Bit-timing margin: slow (+3%) then fast (-3%)
    push_byte(8'hC3);
    send_frame(8'hC3, 1'b1, 1);
    repeat (20) @(negedge clk);
    check("byte_C3_slow", {24'd0, received_byte}, 32'hC3);
    // Clear the byte with a different frame so the fast case is distinct.
    push_byte(8'h00);
    send_frame(8'h00, 1'b1, 0);
    repeat (20) @(negedge clk);
    push_byte(8'hC3);
    send_frame(8'hC3, 1'b1, 2);
    repeat (20) @(negedge clk);
    check("byte_C3_fast", {24'd0, received_byte}, 32'hC3);

    repeat (40) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
